// File: rtl/muldiv_pkg.sv
// Shared opcodes, FSM states and helpers for the mul/div sequencer.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_MUL_WAIT   = 3'd1,
    S_DIV_LAUNCH = 3'd2,
    S_DIV_WAIT   = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  // MULT/MULTU/DIV/DIVU occupy codes 0..3, so bit 2 clear marks a long op.
  function automatic logic is_long_op(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Decode, multiplier and divider signals seen by the mul/div sequencer.
interface muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic                 ena;
  logic                 op_valid;
  logic [2:0]           op_code;
  logic [WIDTH-1:0]     rs_val;
  logic [WIDTH-1:0]     rt_val;
  logic                 stall;
  logic [WIDTH-1:0]     hi;
  logic [WIDTH-1:0]     lo;
  logic [WIDTH-1:0]     mul_a;
  logic [WIDTH-1:0]     mul_b;
  logic                 mul_signed;
  logic [2*WIDTH-1:0]   mul_z;
  logic                 div_start;
  logic                 div_signed;
  logic [WIDTH-1:0]     div_dividend;
  logic [WIDTH-1:0]     div_divisor;
  logic                 div_busy;
  logic                 div_done;
  logic [WIDTH-1:0]     div_q;
  logic [WIDTH-1:0]     div_r;
  logic                 div_timeout;

  modport slave (
    input  ena, op_valid, op_code, rs_val, rt_val, mul_z,
           div_busy, div_done, div_q, div_r,
    output stall, hi, lo, mul_a, mul_b, mul_signed, div_start,
           div_signed, div_dividend, div_divisor, div_timeout
  );

  modport master (
    output ena, op_valid, op_code, rs_val, rt_val, mul_z,
           div_busy, div_done, div_q, div_r,
    input  stall, hi, lo, mul_a, mul_b, mul_signed, div_start,
           div_signed, div_dividend, div_divisor, div_timeout
  );
endinterface

// File: rtl/muldiv_hilo.sv
// HI/LO register pair with independent write enables, frozen while ena is low.
module muldiv_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena_i,
  input  logic             hi_we_i,
  input  logic [WIDTH-1:0] hi_dat_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] lo_dat_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (ena_i) begin
      if (hi_we_i) hi_q <= hi_dat_i;
      if (lo_we_i) lo_q <= lo_dat_i;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// Mul/div sequencer: launches multiplier/divider, owns HI/LO, stalls the PC
// until the result lands; divide-by-zero and divider timeout finish locally.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MUL_LAT     = 1,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  muldiv_ctrl_if.slave   bus
);

  localparam int MCW = 4;
  localparam int TCW = $clog2(DIV_TIMEOUT + 1);

  state_t           state_q, state_d;
  logic [MCW-1:0]   mcnt_q, mcnt_d;
  logic [TCW-1:0]   tcnt_q, tcnt_d;
  logic [WIDTH-1:0] mul_a_q, mul_a_d;
  logic [WIDTH-1:0] mul_b_q, mul_b_d;
  logic             mul_signed_q, mul_signed_d;
  logic [WIDTH-1:0] div_dividend_q, div_dividend_d;
  logic [WIDTH-1:0] div_divisor_q, div_divisor_d;
  logic             div_signed_q, div_signed_d;
  logic             div_timeout_q, div_timeout_d;

  logic             div_start;
  logic             hi_we, lo_we;
  logic [WIDTH-1:0] hi_wd, lo_wd;

  always_comb begin
    state_d        = state_q;
    mcnt_d         = mcnt_q;
    tcnt_d         = tcnt_q;
    mul_a_d        = mul_a_q;
    mul_b_d        = mul_b_q;
    mul_signed_d   = mul_signed_q;
    div_dividend_d = div_dividend_q;
    div_divisor_d  = div_divisor_q;
    div_signed_d   = div_signed_q;
    div_timeout_d  = div_timeout_q;
    div_start      = 1'b0;
    hi_we          = 1'b0;
    lo_we          = 1'b0;
    hi_wd          = '0;
    lo_wd          = '0;

    if (bus.ena) begin
      case (state_q)
        S_IDLE: begin
          if (bus.op_valid) begin
            case (bus.op_code)
              OP_MULT, OP_MULTU: begin
                mul_a_d      = bus.rs_val;
                mul_b_d      = bus.rt_val;
                mul_signed_d = (bus.op_code == OP_MULT);
                mcnt_d       = MCW'(MUL_LAT);
                state_d      = S_MUL_WAIT;
              end
              OP_DIV, OP_DIVU: begin
                if (bus.rt_val != '0) begin
                  div_dividend_d = bus.rs_val;
                  div_divisor_d  = bus.rt_val;
                  div_signed_d   = (bus.op_code == OP_DIV);
                  state_d        = S_DIV_LAUNCH;
                end else begin
                  hi_we   = 1'b1;
                  hi_wd   = bus.rs_val;
                  lo_we   = 1'b1;
                  lo_wd   = '1;
                  state_d = S_DONE;
                end
              end
              OP_MTHI: begin
                hi_we = 1'b1;
                hi_wd = bus.rs_val;
              end
              OP_MTLO: begin
                lo_we = 1'b1;
                lo_wd = bus.rs_val;
              end
              default: ;
            endcase
          end
        end
        S_MUL_WAIT: begin
          mcnt_d = mcnt_q - 1'b1;
          if (mcnt_q == MCW'(1)) begin
            hi_we   = 1'b1;
            hi_wd   = bus.mul_z[2*WIDTH-1:WIDTH];
            lo_we   = 1'b1;
            lo_wd   = bus.mul_z[WIDTH-1:0];
            state_d = S_DONE;
          end
        end
        S_DIV_LAUNCH: begin
          // A divider orphaned by a reset mid-op may still be running.
          tcnt_d = '0;
          if (!bus.div_busy) begin
            div_start = 1'b1;
            state_d   = S_DIV_WAIT;
          end
        end
        S_DIV_WAIT: begin
          tcnt_d = tcnt_q + 1'b1;
          if (bus.div_done) begin
            hi_we   = 1'b1;
            hi_wd   = bus.div_r;
            lo_we   = 1'b1;
            lo_wd   = bus.div_q;
            state_d = S_DONE;
          end else if (tcnt_q == TCW'(DIV_TIMEOUT - 1)) begin
            div_timeout_d = 1'b1;
            state_d       = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      mcnt_q         <= '0;
      tcnt_q         <= '0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      mul_signed_q   <= 1'b0;
      div_dividend_q <= '0;
      div_divisor_q  <= '0;
      div_signed_q   <= 1'b0;
      div_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      mcnt_q         <= mcnt_d;
      tcnt_q         <= tcnt_d;
      mul_a_q        <= mul_a_d;
      mul_b_q        <= mul_b_d;
      mul_signed_q   <= mul_signed_d;
      div_dividend_q <= div_dividend_d;
      div_divisor_q  <= div_divisor_d;
      div_signed_q   <= div_signed_d;
      div_timeout_q  <= div_timeout_d;
    end
  end

  muldiv_hilo #(.WIDTH(WIDTH)) u_hilo (
    .clk      (clk),
    .rst      (rst),
    .ena_i    (bus.ena),
    .hi_we_i  (hi_we),
    .hi_dat_i (hi_wd),
    .lo_we_i  (lo_we),
    .lo_dat_i (lo_wd),
    .hi_o     (bus.hi),
    .lo_o     (bus.lo)
  );

  // DONE is the cycle the PC advances, so the same instruction must not stall there.
  assign bus.stall        = bus.op_valid & is_long_op(bus.op_code) & (state_q != S_DONE);
  assign bus.div_start    = div_start;
  assign bus.mul_a        = mul_a_q;
  assign bus.mul_b        = mul_b_q;
  assign bus.mul_signed   = mul_signed_q;
  assign bus.div_dividend = div_dividend_q;
  assign bus.div_divisor  = div_divisor_q;
  assign bus.div_signed   = div_signed_q;
  assign bus.div_timeout  = div_timeout_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl with behavioural multiplier and 33-cycle divider.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int DIV_LAT = 33;
  localparam int K_RST   = 0;
  localparam int K_LONG  = 1;
  localparam int K_MOVE  = 2;

  typedef struct {
    int          kind;
    string       name;
    int          stall_n;
    int          starts;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        tmo;
    logic        chk_ms;
    logic        ms;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic div_hang;
  int   checks = 0;
  int   passes = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  muldiv_ctrl_if #(.WIDTH(32)) bus ();

  muldiv_ctrl #(.WIDTH(32), .MUL_LAT(1), .DIV_TIMEOUT(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Multiplier with MUL_LAT=1: product of the registered operands.
  logic [63:0] ea, eb;
  always_comb begin
    ea = bus.mul_signed ? {{32{bus.mul_a[31]}}, bus.mul_a} : {32'b0, bus.mul_a};
    eb = bus.mul_signed ? {{32{bus.mul_b[31]}}, bus.mul_b} : {32'b0, bus.mul_b};
  end
  assign bus.mul_z = ea * eb;

  // Divider: done pulses in the 33rd cycle after the start edge; never when hung.
  int          dcnt = 0;
  logic [31:0] dq = '0, dr = '0;
  always @(posedge clk) begin
    if (bus.div_start && !div_hang) begin
      dcnt <= 1;
      if (bus.div_signed) begin
        dq <= 32'($signed(bus.div_dividend) / $signed(bus.div_divisor));
        dr <= 32'($signed(bus.div_dividend) % $signed(bus.div_divisor));
      end else begin
        dq <= bus.div_dividend / bus.div_divisor;
        dr <= bus.div_dividend % bus.div_divisor;
      end
    end else if (dcnt == DIV_LAT) begin
      dcnt <= 0;
    end else if (dcnt != 0) begin
      dcnt <= dcnt + 1;
    end
  end
  assign bus.div_done = (dcnt == DIV_LAT);
  assign bus.div_busy = (dcnt != 0);
  assign bus.div_q    = dq;
  assign bus.div_r    = dr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: pops on reset assertion, on a move's write edge and on stall release.
  int   stall_run = 0;
  int   start_run = 0;
  logic stall_prev = 1'b0;
  logic rst_prev = 1'b0;
  logic mv_pend = 1'b0;
  logic mv_stall = 1'b0;

  task automatic pop_check(input int kind);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      $display("FAIL unexpected_output: kind %0d with empty scoreboard", kind);
      return;
    end
    e = sb.pop_front();
    chk({e.name, ".kind"}, 64'(kind), 64'(e.kind));
    chk({e.name, ".hi"}, 64'(bus.hi), 64'(e.hi));
    chk({e.name, ".lo"}, 64'(bus.lo), 64'(e.lo));
    chk({e.name, ".div_timeout"}, 64'(bus.div_timeout), 64'(e.tmo));
    if (kind == K_RST) begin
      chk({e.name, ".stall"}, 64'(bus.stall), 64'(0));
      chk({e.name, ".div_start"}, 64'(bus.div_start), 64'(0));
      chk({e.name, ".mul_ab"}, {bus.mul_a, bus.mul_b}, 64'(0));
      chk({e.name, ".div_ops"}, {bus.div_dividend, bus.div_divisor}, 64'(0));
      chk({e.name, ".signed"}, 64'({bus.mul_signed, bus.div_signed}), 64'(0));
    end else if (kind == K_MOVE) begin
      chk({e.name, ".stall"}, 64'(mv_stall), 64'(e.stall_n));
    end else begin
      chk({e.name, ".stall_cycles"}, 64'(stall_run), 64'(e.stall_n));
      chk({e.name, ".div_starts"}, 64'(start_run), 64'(e.starts));
      if (e.chk_ms) chk({e.name, ".mul_signed"}, 64'(bus.mul_signed), 64'(e.ms));
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (!rst_prev) pop_check(K_RST);
      rst_prev   = 1'b1;
      stall_run  = 0;
      start_run  = 0;
      stall_prev = 1'b0;
      mv_pend    = 1'b0;
    end else begin
      rst_prev = 1'b0;
      if (mv_pend) begin
        pop_check(K_MOVE);
        mv_pend = 1'b0;
      end
      if (bus.div_start) start_run++;
      if (bus.stall) begin
        stall_run++;
      end else if (stall_prev) begin
        pop_check(K_LONG);
        stall_run = 0;
        start_run = 0;
      end
      if (bus.ena && bus.op_valid && (bus.op_code == OP_MTHI || bus.op_code == OP_MTLO)) begin
        mv_pend  = 1'b1;
        mv_stall = bus.stall;
      end
      stall_prev = bus.stall;
    end
  end

  task automatic push(input int kind, input string name, input int stall_n, input int starts,
                      input logic [31:0] hi, input logic [31:0] lo, input logic tmo,
                      input logic chk_ms, input logic ms);
    exp_t e;
    e.kind = kind; e.name = name; e.stall_n = stall_n; e.starts = starts;
    e.hi = hi; e.lo = lo; e.tmo = tmo; e.chk_ms = chk_ms; e.ms = ms;
    sb.push_back(e);
  endtask

  task automatic wait_stall_low(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.stall && n < 300);
    if (bus.stall) begin
      checks++;
      $display("FAIL %s.timeout: stall still high after %0d cycles, expected release", name, n);
    end
  endtask

  task automatic long_op(input string name, input logic [2:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input int freeze_n, input int stall_n,
                         input int starts, input logic [31:0] hi, input logic [31:0] lo,
                         input logic tmo, input logic chk_ms, input logic ms);
    push(K_LONG, name, stall_n, starts, hi, lo, tmo, chk_ms, ms);
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.op_code = op; bus.rs_val = rs; bus.rt_val = rt;
    if (freeze_n > 0) begin
      @(posedge clk); #1 bus.ena = 1'b0;
      repeat (freeze_n) @(posedge clk);
      #1 bus.ena = 1'b1;
    end
    wait_stall_low(name);
    // op_valid stays high through DONE, as the decoder would present it.
    @(posedge clk); #1 bus.op_valid = 1'b0;
  endtask

  task automatic move_op(input string name, input logic [2:0] op, input logic [31:0] rs,
                         input logic [31:0] hi, input logic [31:0] lo, input logic tmo);
    push(K_MOVE, name, 0, 0, hi, lo, tmo, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.op_code = op; bus.rs_val = rs; bus.rt_val = '0;
    @(posedge clk); #1 bus.op_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; div_hang = 1'b0;
    bus.ena = 1'b1; bus.op_valid = 1'b0; bus.op_code = '0; bus.rs_val = '0; bus.rt_val = '0;
    push(K_RST, "reset", 0, 0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    long_op("mult_neg3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 0, 2, 0,
            32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b1, 1'b1);
    long_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 0, 35, 1,
            32'd2, 32'd14, 1'b0, 1'b0, 1'b0);
    long_op("div_5_0", OP_DIV, 32'd5, 32'd0, 0, 1, 0,
            32'd5, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    move_op("mthi", OP_MTHI, 32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0);
    move_op("mtlo", OP_MTLO, 32'h9, 32'h1234_5678, 32'h9, 1'b0);
    long_op("multu_max_x2", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 0, 2, 0,
            32'h1, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0);

    div_hang = 1'b1;
    long_op("divu_timeout", OP_DIVU, 32'd100, 32'd7, 0, 66, 1,
            32'h1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    div_hang = 1'b0;

    long_op("mult_ena_freeze", OP_MULT, 32'd6, 32'hFFFF_FFFE, 5, 7, 0,
            32'hFFFF_FFFF, 32'hFFFF_FFF4, 1'b1, 1'b1, 1'b1);

    // Reset during DIV_WAIT; the divider keeps running and pulses done later.
    push(K_RST, "reset_midop", 0, 0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.op_code = OP_DIVU; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1; bus.op_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(posedge clk);
    move_op("mthi_after_late_done", OP_MTHI, 32'hA5, 32'hA5, 32'h0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
